// File: rtl/jtcontra_snd_comm.sv
// Command mailbox from the main CPU to the sound CPU: a small circular FIFO with
// a selectable IRQ style, overflow handling and a one-entry reply latch back.
module jtcontra_snd_comm #(
  parameter int DW       = 8,
  parameter int AW       = 2,
  parameter int OVWR     = 0,
  parameter int IRQ_MODE = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          main_wr,
  input  logic [DW-1:0] main_din,
  input  logic          snd_rd,
  output logic [DW-1:0] snd_dout,
  output logic          snd_irq_n,
  input  logic          irq_clr,
  output logic [AW:0]   fill,
  output logic          empty,
  output logic          full,
  output logic          ovf,
  input  logic          snd_wr,
  input  logic [DW-1:0] snd_din,
  output logic [DW-1:0] main_dout,
  output logic          main_rdy,
  input  logic          main_ack
);

  localparam int DEPTH = 1 << AW;
  localparam int PW    = (AW > 0) ? AW : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // Handshake: every strobe is a single-cycle pulse with no ready/back-pressure;
  // the sender learns whether a push was taken from fill/full/ovf one cycle later.
  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   fill_q, fill_d;
  logic [DW-1:0] hold_q, hold_d;
  logic [DW-1:0] main_dout_q, main_dout_d;
  logic          ovf_q, ovf_d;
  logic          irq_q, irq_d;
  logic          main_rdy_q, main_rdy_d;
  logic          empty_w, full_w;
  logic          push_ok, pop_ok, ovw;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (DEPTH == 1) return '0;
    return p + PW'(1);
  endfunction

  always_comb begin
    empty_w = (fill_q == '0);
    full_w  = (fill_q == FULL_CNT);
    pop_ok  = snd_rd & ~empty_w;
    // Overwrite only when full with no pop: the oldest entry is sacrificed.
    ovw     = main_wr & full_w & ~snd_rd & (OVWR != 0);
    push_ok = main_wr & (~full_w | snd_rd | (OVWR != 0));

    fill_d = fill_q;
    if (push_ok && !pop_ok && !ovw) fill_d = fill_q + (AW+1)'(1);
    else if (pop_ok && !push_ok)    fill_d = fill_q - (AW+1)'(1);

    wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = (pop_ok || ovw) ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    hold_d   = pop_ok ? mem_q[rd_ptr_q] : hold_q;
    ovf_d    = ovf_q | (main_wr & full_w & ~snd_rd);

    // A push in the same cycle as irq_clr keeps the flag so no command is missed.
    irq_d = irq_q;
    if (push_ok)      irq_d = 1'b1;
    else if (irq_clr) irq_d = 1'b0;

    main_dout_d = snd_wr ? snd_din : main_dout_q;
    main_rdy_d  = main_rdy_q;
    if (snd_wr)        main_rdy_d = 1'b1;
    else if (main_ack) main_rdy_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      hold_q      <= '0;
      ovf_q       <= 1'b0;
      irq_q       <= 1'b0;
      main_dout_q <= '0;
      main_rdy_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      hold_q      <= hold_d;
      ovf_q       <= ovf_d;
      irq_q       <= irq_d;
      main_dout_q <= main_dout_d;
      main_rdy_q  <= main_rdy_d;
    end
  end

  // Storage has no reset; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= main_din;
  end

  assign snd_dout  = empty_w ? hold_q : mem_q[rd_ptr_q];
  assign snd_irq_n = (IRQ_MODE != 0) ? ~irq_q : empty_w;
  assign fill      = fill_q;
  assign empty     = empty_w;
  assign full      = full_w;
  assign ovf       = ovf_q;
  assign main_dout = main_dout_q;
  assign main_rdy  = main_rdy_q;

endmodule

// File: doc/jtcontra_snd_comm.md
# jtcontra_snd_comm

Parametrised command mailbox between the main CPU and the sound CPU. It replaces the single 8-bit sound latch and edge-triggered IRQ flip-flop with a FIFO of configurable width and depth, a selectable interrupt mode, overflow handling and a reply latch from the sound CPU back to the main CPU. It sits between the main-CPU write decode and the sound CPU data-in multiplexer, and drives the sound CPU `nIRQ`.

## Interface
Parameters:
- `DW`, 8: data width of commands and replies.
- `AW`, 2: FIFO address width; depth is 2^AW entries. AW=0 gives a 1-deep FIFO (plain latch).
- `OVWR`, 0: behaviour on a write when full. 0 drops the new entry; 1 discards the oldest entry and appends the new one.
- `IRQ_MODE`, 0: 0 makes `snd_irq_n` a level signal, low while the FIFO is non-empty. 1 makes it a latched flag, set by each accepted write and cleared by `irq_clr`.

Ports:
- `clk`  in  1  system clock (24 MHz).
- `rst`  in  1  asynchronous reset, active-high.
- `main_wr`  in  1  one-cycle pulse: push `main_din`.
- `main_din`  in  DW  command from the main CPU.
- `snd_rd`  in  1  one-cycle pulse: pop the head entry.
- `snd_dout`  out  DW  head entry. Holds the last popped value when the FIFO is empty.
- `snd_irq_n`  out  1  interrupt to the sound CPU, active low.
- `irq_clr`  in  1  one-cycle pulse: clear the latched IRQ (used in IRQ_MODE=1 only).
- `fill`  out  AW+1  number of stored entries.
- `empty`, `full`  out  1  FIFO status.
- `ovf`  out  1  sticky overflow flag.
- `snd_wr`  in  1  one-cycle pulse: write `snd_din` to the reply latch.
- `snd_din`  in  DW  reply data from the sound CPU.
- `main_dout`  out  DW  reply latch contents.
- `main_rdy`  out  1  reply pending.
- `main_ack`  in  1  one-cycle pulse: clear `main_rdy`.

## Operation
- Storage: circular buffer with `wr_ptr` and `rd_ptr` of AW bits and a `fill` counter of AW+1 bits. Both pointers wrap modulo 2^AW.
- Push accepted when `main_wr` is high and the FIFO is not full: write `mem[wr_ptr]`, advance `wr_ptr`, increment `fill`.
- Pop accepted when `snd_rd` is high and the FIFO is not empty: advance `rd_ptr`, decrement `fill`, and capture the popped value into the hold register.
- `snd_dout` equals `mem[rd_ptr]` when not empty, otherwise the hold register.
- Push and pop in the same cycle when neither full nor empty: both are performed and `fill` is unchanged.
- Full FIFO with push and pop in the same cycle: both are performed, `fill` is unchanged, `ovf` is not set.
- Empty FIFO with push and pop in the same cycle: the pop is ignored, the push is accepted, and `fill` becomes 1.
- `snd_rd` while empty with no push: no state change.
- Full FIFO, push, no pop, OVWR=0: the data is dropped and `ovf` is set.
- Full FIFO, push, no pop, OVWR=1: `rd_ptr` and `wr_ptr` both advance, the new data is written, `fill` stays 2^AW, and `ovf` is set.
- `ovf` clears only on `rst`.
- IRQ_MODE=0: `snd_irq_n` is the inverse of non-empty (`snd_irq_n = empty`). `irq_clr` is ignored.
- IRQ_MODE=1: the IRQ flag is set by any accepted push, including an overwrite, and cleared by `irq_clr`. If both happen in the same cycle, set wins so no command is lost. `snd_irq_n` is the inverse of the flag.
- Reply latch: `snd_wr` loads `main_dout` and sets `main_rdy`. `main_ack` clears `main_rdy`. If `snd_wr` and `main_ack` happen in the same cycle, the load happens and `main_rdy` stays set.
- Reset values: pointers 0, `fill` 0, `empty` 1, `full` 0, `ovf` 0, IRQ flag 0, `snd_irq_n` 1, `snd_dout` 0, `main_dout` 0, `main_rdy` 0. Memory contents are don't-care.
- Reset asserted mid-operation: all of the above take effect immediately (asynchronous). Pending commands are lost.

## Timing
- All state is registered on the rising edge of `clk`. Strobes are sampled every cycle; the caller qualifies them with its own CPU clock enable and must deliver single-cycle pulses.
- Push at cycle n: `fill`, `empty`, `full` and `snd_irq_n` update at n+1. `snd_dout` shows the new entry at n+1 if the FIFO was empty.
- Pop at cycle n: `snd_dout` shows the next entry, or the held value, at n+1.
- `irq_clr` at n: `snd_irq_n` is high at n+1 unless a push was accepted at n.
- `snd_wr` at n: `main_dout` and `main_rdy` are valid at n+1.
- No combinational path from any strobe input to any output.

## Test plan
- Reset, then push 0x12, 0x34, 0x56 with AW=2 -> `fill`=3, `snd_dout`=0x12, `snd_irq_n`=0. Three pops -> values 0x12, 0x34, 0x56 in order, then `empty`=1, `snd_dout` holds 0x56, `snd_irq_n`=1 (mode 0).
- AW=2, OVWR=0: push 0x01..0x05 -> `full`=1, `ovf`=1, 0x05 dropped, pops return 0x01..0x04. Repeat with OVWR=1 -> pops return 0x02..0x05.
- Full FIFO, push 0xAA and pop in the same cycle -> `fill` stays 4, `ovf` stays 0, 0xAA read last. Empty FIFO, push and pop together -> `fill`=1.
- IRQ_MODE=1: push 0x10 -> `snd_irq_n`=0 at n+1. `irq_clr` -> 1. `irq_clr` coincident with a push -> stays 0.
- Reply path: `snd_wr` with 0x7F -> `main_dout`=0x7F, `main_rdy`=1. `main_ack` -> 0. `snd_wr` coincident with `main_ack` -> `main_rdy`=1.
- Assert `rst` asynchronously with `fill`=3 -> all outputs return to reset values without waiting for a clock edge. First push after release reads back correctly.
